// File: rtl/interval_timer.sv
// Per-phase countdown timer feeding the workout FSM's time_done input.
// Reloads work/rest duration on each phase entry and presents remaining time as binary and mm:ss BCD.
//
//   state      | meaning
//   ST_STOP    | idle, outputs cleared, waiting for a workout/rest phase
//   ST_RUN     | counting down one second per tick
//   ST_EXPIRED | reached 0, time_done pulsed, waiting for next phase or stop
module interval_timer #(
    parameter int TICK_DIV = 1,
    parameter int WARN_SEC = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_timer,
    input  logic [1:0] state_in,
    input  logic       pause,
    input  logic [7:0] work_sec,
    input  logic [7:0] rest_sec,
    output logic       time_done,
    output logic [7:0] remaining,
    output logic [2:0] min_digit,
    output logic [2:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       warn
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_EXPIRED} state_e;

    state_e        state_q;
    logic [1:0]    phase_q;
    logic [7:0]    rem_q;
    logic [2:0]    min_q;
    logic [2:0]    tens_q;
    logic [3:0]    ones_q;
    logic          done_q;
    logic [PW-1:0] presc_q;

    logic       stop_c;
    logic       load_c;
    logic       tick_c;
    logic [7:0] load_raw;
    logic [7:0] load_val;
    logic [2:0] ld_min;
    logic [2:0] ld_tens;
    logic [3:0] ld_ones;
    logic [2:0] dec_min;
    logic [2:0] dec_tens;
    logic [3:0] dec_ones;

    assign stop_c   = !start_timer || (state_in == 2'b00) || (state_in == 2'b11);
    assign load_c   = !stop_c && (state_in != phase_q);
    assign load_raw = (state_in == 2'b01) ? work_sec : rest_sec;
    assign load_val = (load_raw == 8'd0) ? 8'd1 : load_raw;
    assign tick_c   = (TICK_DIV == 1) ? 1'b1 : (presc_q == PW'(TICK_DIV - 1));

    assign ld_min  = 3'(load_val / 8'd60);
    assign ld_tens = 3'((load_val % 8'd60) / 8'd10);
    assign ld_ones = 4'((load_val % 8'd60) % 8'd10);

    // BCD borrow chain kept in lockstep with the binary count
    assign dec_ones = (ones_q == 4'd0) ? 4'd9 : ones_q - 4'd1;
    assign dec_tens = (ones_q != 4'd0) ? tens_q :
                      ((tens_q == 3'd0) ? 3'd5 : tens_q - 3'd1);
    assign dec_min  = ((ones_q == 4'd0) && (tens_q == 3'd0)) ? min_q - 3'd1 : min_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_STOP;
            phase_q <= 2'b00;
            rem_q   <= 8'd0;
            min_q   <= 3'd0;
            tens_q  <= 3'd0;
            ones_q  <= 4'd0;
            done_q  <= 1'b0;
            presc_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (stop_c) begin
                state_q <= ST_STOP;
                phase_q <= 2'b00;
                rem_q   <= 8'd0;
                min_q   <= 3'd0;
                tens_q  <= 3'd0;
                ones_q  <= 4'd0;
                presc_q <= '0;
            end else if (load_c) begin
                state_q <= ST_RUN;
                phase_q <= state_in;
                rem_q   <= load_val;
                min_q   <= ld_min;
                tens_q  <= ld_tens;
                ones_q  <= ld_ones;
                presc_q <= '0;
            end else if ((state_q == ST_RUN) && !pause) begin
                if (tick_c) begin
                    presc_q <= '0;
                    rem_q   <= rem_q - 8'd1;
                    min_q   <= dec_min;
                    tens_q  <= dec_tens;
                    ones_q  <= dec_ones;
                    if (rem_q == 8'd1) begin
                        done_q  <= 1'b1;
                        state_q <= ST_EXPIRED;
                    end
                end else begin
                    presc_q <= presc_q + PW'(1);
                end
            end
        end
    end

    assign time_done = done_q;
    assign remaining = rem_q;
    assign min_digit = min_q;
    assign sec_tens  = tens_q;
    assign sec_ones  = ones_q;
    assign warn      = (state_q == ST_RUN) && (rem_q != 8'd0) && (rem_q <= 8'(WARN_SEC));

endmodule

// File: tb/tb_interval_timer.sv
// Scoreboard bench for interval_timer: one instance at TICK_DIV=1, one at TICK_DIV=4, shared stimulus.
module tb_interval_timer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start_timer;
    logic [1:0] state_in;
    logic       pause;
    logic [7:0] work_sec;
    logic [7:0] rest_sec;

    logic       time_done,  warn;
    logic [7:0] remaining;
    logic [2:0] min_digit, sec_tens;
    logic [3:0] sec_ones;

    logic       time_done4, warn4;
    logic [7:0] remaining4;
    logic [2:0] min_digit4, sec_tens4;
    logic [3:0] sec_ones4;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string tag;
        int    sel;
        int    val;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    interval_timer #(.TICK_DIV(1), .WARN_SEC(3)) dut (
        .clk(clk), .reset_n(reset_n), .start_timer(start_timer), .state_in(state_in),
        .pause(pause), .work_sec(work_sec), .rest_sec(rest_sec), .time_done(time_done),
        .remaining(remaining), .min_digit(min_digit), .sec_tens(sec_tens),
        .sec_ones(sec_ones), .warn(warn)
    );

    interval_timer #(.TICK_DIV(4), .WARN_SEC(3)) dut4 (
        .clk(clk), .reset_n(reset_n), .start_timer(start_timer), .state_in(state_in),
        .pause(pause), .work_sec(work_sec), .rest_sec(rest_sec), .time_done(time_done4),
        .remaining(remaining4), .min_digit(min_digit4), .sec_tens(sec_tens4),
        .sec_ones(sec_ones4), .warn(warn4)
    );

    task automatic chk(input string tag, input int got, input int want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic int obs(input int sel);
        case (sel)
            0:       return int'(remaining);
            1:       return int'(time_done);
            2:       return int'(warn);
            3:       return int'(min_digit) * 100 + int'(sec_tens) * 10 + int'(sec_ones);
            4:       return int'(remaining4);
            5:       return int'(time_done4);
            6:       return int'(min_digit4) * 100 + int'(sec_tens4) * 10 + int'(sec_ones4);
            default: return -1;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input int val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic exp4(input string tag, input int r, input int d, input int w, input int disp);
        push({tag, ".rem"},  0, r);
        push({tag, ".done"}, 1, d);
        push({tag, ".warn"}, 2, w);
        push({tag, ".disp"}, 3, disp);
    endtask

    task automatic flush();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, obs(e.sel), e.val);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        flush();
    endtask

    initial begin
        reset_n     = 1'b0;
        start_timer = 1'b0;
        state_in    = 2'b00;
        pause       = 1'b0;
        work_sec    = 8'd0;
        rest_sec    = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        exp4("rst", 0, 0, 0, 0);
        push("rst4.rem", 4, 0);
        push("rst4.done", 5, 0);
        flush();

        // basic countdown from 5
        work_sec = 8'd5; start_timer = 1'b1; state_in = 2'b01; reset_n = 1'b1;
        exp4("cd5", 5, 0, 0, 5);  step();
        exp4("cd4", 4, 0, 0, 4);  step();
        exp4("cd3", 3, 0, 1, 3);  step();
        exp4("cd2", 2, 0, 1, 2);  step();
        exp4("cd1", 1, 0, 1, 1);  step();
        exp4("cd0", 0, 1, 0, 0);  step();
        exp4("cdx", 0, 0, 0, 0);  step();
        exp4("cdx2", 0, 0, 0, 0); step();

        // BCD borrows
        rest_sec = 8'd130; state_in = 2'b10;
        exp4("b130", 130, 0, 0, 210); step();
        exp4("b129", 129, 0, 0, 209); step();
        repeat (8) step();
        exp4("b120", 120, 0, 0, 200); step();
        exp4("b119", 119, 0, 0, 159); step();
        work_sec = 8'd255; state_in = 2'b01;
        exp4("b255", 255, 0, 0, 415); step();

        // phase skip mid-count
        start_timer = 1'b0;
        exp4("stp", 0, 0, 0, 0); step();
        start_timer = 1'b1; work_sec = 8'd9;
        exp4("sk9", 9, 0, 0, 9); step();
        exp4("sk8", 8, 0, 0, 8); step();
        exp4("sk7", 7, 0, 0, 7); step();
        state_in = 2'b10; rest_sec = 8'd3;
        exp4("sk3", 3, 0, 1, 3); step();
        exp4("sk2", 2, 0, 1, 2); step();
        exp4("sk1", 1, 0, 1, 1); step();
        exp4("sk0", 0, 1, 0, 0); step();
        exp4("skx", 0, 0, 0, 0); step();

        // zero duration clamps to 1, then FINISH stops
        state_in = 2'b01; work_sec = 8'd0;
        exp4("z1", 1, 0, 1, 1); step();
        exp4("z0", 0, 1, 0, 0); step();
        state_in = 2'b11;
        exp4("fin", 0, 0, 0, 0);  step();
        exp4("fin2", 0, 0, 0, 0); step();

        // load on the same edge as the 1->0 tick
        state_in = 2'b01; work_sec = 8'd2;
        exp4("lt2", 2, 0, 1, 2); step();
        exp4("lt1", 1, 0, 1, 1); step();
        state_in = 2'b10; rest_sec = 8'd6;
        exp4("lt6", 6, 0, 0, 6); step();
        exp4("lt5", 5, 0, 0, 5); step();

        // pause on tick edges
        pause = 1'b1;
        exp4("ps_a", 5, 0, 0, 5); step();
        exp4("ps_b", 5, 0, 0, 5); step();
        pause = 1'b0;
        exp4("ps_c", 4, 0, 0, 4); step();

        // prescaler with pause mid-second
        start_timer = 1'b0;
        push("p4.stop", 4, 0); step();
        start_timer = 1'b1; state_in = 2'b01; work_sec = 8'd2;
        push("p4.load", 4, 2); push("p4.disp", 6, 2); step();
        push("p4.c1", 4, 2); step();
        push("p4.c2", 4, 2); step();
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push("p4.hold", 4, 2);
            push("p4.hdone", 5, 0);
            step();
        end
        pause = 1'b0;
        push("p4.c3", 4, 2); step();
        push("p4.t1", 4, 1); push("p4.t1disp", 6, 1); step();
        for (int i = 0; i < 3; i++) begin
            push("p4.w", 4, 1);
            push("p4.wdone", 5, 0);
            step();
        end
        push("p4.end", 4, 0); push("p4.done", 5, 1); step();
        push("p4.done_clr", 5, 0); step();

        // asynchronous reset mid-run
        start_timer = 1'b0; step();
        start_timer = 1'b1; state_in = 2'b01; work_sec = 8'd20;
        exp4("ar20", 20, 0, 0, 20); step();
        step();
        exp4("ar18", 18, 0, 0, 18); step();
        #3 reset_n = 1'b0;
        #1;
        exp4("ar_now", 0, 0, 0, 0);
        push("ar_now4.rem", 4, 0);
        push("ar_now4.done", 5, 0);
        flush();
        @(posedge clk);
        #1;
        exp4("ar_hold", 0, 0, 0, 0);
        flush();
        reset_n = 1'b1;
        exp4("ar_rel", 20, 0, 0, 20); step();
        exp4("ar_19", 19, 0, 0, 19);  step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
